// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 VGA timing constants, derived totals and sync window bounds.
// The text generator and maze renderer import this for their visible-area bounds.
package vga_timing_pkg;

    // Width of the pixel_x / pixel_y coordinate buses; totals must fit in it.
    localparam int COORD_W = 10;
    typedef logic [COORD_W-1:0] coord_t;

    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;

    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    // Inclusive sync windows (656..751 and 490..491 for the defaults).
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // True when pos lies in the inclusive window [first, last].
    function automatic logic in_window(input coord_t pos, input coord_t first, input coord_t last);
        return (pos >= first) && (pos <= last);
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Scan-timing bundle produced by vga_sync_gen and consumed by the display path.
//
// Handshake: p_tick is the only qualifier. The stream has no ready/backpressure;
// coordinates, video_on and syncs are stable for a whole pixel period and change
// only on the clk edge that closes a p_tick cycle, so consumers may sample them
// in any cycle and use p_tick when they need one action per pixel.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   hsync;
    logic   vsync;
    logic   frame_start;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );

    modport slave (
        input p_tick, pixel_x, pixel_y, video_on, hsync, vsync, frame_start
    );

endinterface

// File: rtl/mod_m_counter.sv
// Wrap-at-M counter with enable. Exposes the current count, the value it will
// take on the next edge, and a max-tick flag that is high while count == M-1.
module mod_m_counter #(
    parameter int M = 2,
    parameter int W = (M > 1) ? $clog2(M) : 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic [W-1:0] cnt_next_o,
    output logic         max_tick_o
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: hold unless enabled, wrap to zero after the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign cnt_next_o = cnt_d;
    assign max_tick_o = (cnt_q == LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator: clock divider -> horizontal counter -> vertical counter,
// with sync pulses registered from the counters' next values so they line up
// with the coordinates they describe.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = vga_timing_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_DISPLAY = vga_timing_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic            clk,
    input  logic            reset_n,
    vga_sync_gen_if.master  vga_if
);

    localparam int H_TOT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam coord_t H_DISP_C   = coord_t'(H_DISPLAY);
    localparam coord_t V_DISP_C   = coord_t'(V_DISPLAY);
    localparam coord_t HS_FIRST_C = coord_t'(H_DISPLAY + H_FRONT);
    localparam coord_t HS_LAST_C  = coord_t'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam coord_t VS_FIRST_C = coord_t'(V_DISPLAY + V_FRONT);
    localparam coord_t VS_LAST_C  = coord_t'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    // Counters must fit the coordinate buses and the divider needs at least one clock.
    if (CLK_DIV < 1 || H_TOT > (1 << COORD_W) || V_TOT > (1 << COORD_W)) begin : g_param_check
        $error("vga_sync_gen: CLK_DIV must be >= 1 and H/V totals must not exceed 1024");
    end

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_next;
    logic             p_tick;
    coord_t           h_cnt;
    coord_t           h_next;
    logic             h_last;
    coord_t           v_cnt;
    coord_t           v_next;
    logic             v_last;
    logic             hsync_q;
    logic             hsync_d;
    logic             vsync_q;
    logic             vsync_d;

    // Pixel-rate divider; its max tick is the pixel strobe.
    mod_m_counter #(.M(CLK_DIV), .W(DIV_W)) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (1'b1),
        .cnt_o      (div_cnt),
        .cnt_next_o (div_next),
        .max_tick_o (p_tick)
    );

    // Horizontal scan position, one step per pixel.
    mod_m_counter #(.M(H_TOT), .W(COORD_W)) u_h (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (p_tick),
        .cnt_o      (h_cnt),
        .cnt_next_o (h_next),
        .max_tick_o (h_last)
    );

    // Vertical scan position, one step per completed line; wraps with h on the same edge.
    mod_m_counter #(.M(V_TOT), .W(COORD_W)) u_v (
        .clk        (clk),
        .reset_n    (reset_n),
        .en_i       (p_tick & h_last),
        .cnt_o      (v_cnt),
        .cnt_next_o (v_next),
        .max_tick_o (v_last)
    );

    // Only the divider's max tick and the vertical count itself are needed here.
    logic unused_cnt_bits;
    assign unused_cnt_bits = ^{div_cnt, div_next, v_last};

    // Sync decode from the next counter values, so the registered pulse matches the new coordinate.
    always_comb begin
        hsync_d = !in_window(h_next, HS_FIRST_C, HS_LAST_C);
        vsync_d = !in_window(v_next, VS_FIRST_C, VS_LAST_C);
    end

    // Sync registers; idle high while in reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
        end
    end

    assign vga_if.p_tick      = p_tick;
    assign vga_if.pixel_x     = h_cnt;
    assign vga_if.pixel_y     = v_cnt;
    assign vga_if.video_on    = (h_cnt < H_DISP_C) && (v_cnt < V_DISP_C);
    assign vga_if.hsync       = hsync_q;
    assign vga_if.vsync       = vsync_q;
    assign vga_if.frame_start = p_tick && (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default 640x480 timing at CLK_DIV=2,
// and two small rasters at CLK_DIV=1 and CLK_DIV=3) share a clock and a reset
// that is pulsed at random points, including between clock edges.
module tb_vga_sync_gen;
    import vga_timing_pkg::*;

    localparam int CLK_HALF = 5;

    localparam int B_DIV = 1;
    localparam int B_HD = 10, B_HF = 2, B_HS = 3, B_HB = 1;
    localparam int B_VD = 6,  B_VF = 1, B_VS = 2, B_VB = 1;

    localparam int C_DIV = 3;
    localparam int C_HD = 8, C_HF = 2, C_HS = 2, C_HB = 3;
    localparam int C_VD = 5, C_VF = 2, C_VS = 1, C_VB = 2;

    typedef logic [24:0] vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    logic [24:0] exp_a_q[$];
    logic [24:0] exp_b_q[$];
    logic [24:0] exp_c_q[$];

    // ---------------- clock / reset ----------------
    always #CLK_HALF clk = ~clk;

    vga_sync_gen_if a_if ();
    vga_sync_gen_if b_if ();
    vga_sync_gen_if c_if ();

    vga_sync_gen #(.CLK_DIV(2)) dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .vga_if  (a_if)
    );

    vga_sync_gen #(
        .CLK_DIV(B_DIV),
        .H_DISPLAY(B_HD), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_DISPLAY(B_VD), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB)
    ) dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .vga_if  (b_if)
    );

    vga_sync_gen #(
        .CLK_DIV(C_DIV),
        .H_DISPLAY(C_HD), .H_FRONT(C_HF), .H_SYNC(C_HS), .H_BACK(C_HB),
        .V_DISPLAY(C_VD), .V_FRONT(C_VF), .V_SYNC(C_VS), .V_BACK(C_VB)
    ) dut_c (
        .clk     (clk),
        .reset_n (reset_n),
        .vga_if  (c_if)
    );

    // ---------------- reference model ----------------
    // k = clk edges seen since reset release (0 while in reset). Pixel index is
    // k / d; the raster position follows from plain division of that index.
    function automatic vec_t model_vec(input int k, input int d,
                                       input int hd, input int hf, input int hs, input int hb,
                                       input int vd, input int vf, input int vs, input int vb);
        int   ht, vt, n, x, y;
        logic pt, von, hs_n, vs_n, fs;
        ht   = hd + hf + hs + hb;
        vt   = vd + vf + vs + vb;
        n    = k / d;
        pt   = ((k % d) == (d - 1));
        x    = n % ht;
        y    = (n / ht) % vt;
        von  = (x < hd) && (y < vd);
        hs_n = !((x >= hd + hf) && (x < hd + hf + hs));
        vs_n = !((y >= vd + vf) && (y < vd + vf + vs));
        fs   = pt && (x == 0) && (y == 0);
        return {pt, 10'(x), 10'(y), von, hs_n, vs_n, fs};
    endfunction

    function automatic string fmt(input vec_t v);
        return $sformatf("pt=%b x=%0d y=%0d von=%b hs=%b vs=%b fs=%b",
                         v[24], v[23:14], v[13:4], v[3], v[2], v[1], v[0]);
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check_vec(input string name, input vec_t act, input vec_t exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got %s, want %s", name, $time, fmt(act), fmt(exp));
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s t=%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- expectation producer ----------------
    // Pushes one expected output set per clk edge (and on an asynchronous reset).
    initial begin : model
        int k;
        k = 0;
        forever begin
            @(posedge clk or negedge reset_n);
            #1;
            if (!reset_n) begin
                k = 0;
                exp_a_q.delete();
                exp_b_q.delete();
                exp_c_q.delete();
            end else begin
                k++;
            end
            exp_a_q.push_back(model_vec(k, 2, H_DISPLAY, H_FRONT, H_SYNC, H_BACK,
                                        V_DISPLAY, V_FRONT, V_SYNC, V_BACK));
            exp_b_q.push_back(model_vec(k, B_DIV, B_HD, B_HF, B_HS, B_HB, B_VD, B_VF, B_VS, B_VB));
            exp_c_q.push_back(model_vec(k, C_DIV, C_HD, C_HF, C_HS, C_HB, C_VD, C_VF, C_VS, C_VB));
        end
    end

    // ---------------- monitor ----------------
    // Samples on the falling edge, or shortly after a mid-cycle reset assertion
    // (still before the next rising edge), and compares against the queue head.
    initial begin : monitor
        vec_t e;
        int   tick_a, vid_off, hs_low, first_low_x, back_high_x;
        logic hs_prev, line_done;
        tick_a = 0; vid_off = 0; hs_low = 0; first_low_x = -1; back_high_x = -1;
        hs_prev = 1'b1; line_done = 1'b0;
        forever begin
            @(negedge clk or negedge reset_n);
            if (clk) #2;
            if (exp_a_q.size() > 0) begin
                e = exp_a_q.pop_front();
                check_vec("dut_a", {a_if.p_tick, a_if.pixel_x, a_if.pixel_y, a_if.video_on,
                                    a_if.hsync, a_if.vsync, a_if.frame_start}, e);
            end
            if (exp_b_q.size() > 0) begin
                e = exp_b_q.pop_front();
                check_vec("dut_b", {b_if.p_tick, b_if.pixel_x, b_if.pixel_y, b_if.video_on,
                                    b_if.hsync, b_if.vsync, b_if.frame_start}, e);
            end
            if (exp_c_q.size() > 0) begin
                e = exp_c_q.pop_front();
                check_vec("dut_c", {c_if.p_tick, c_if.pixel_x, c_if.pixel_y, c_if.video_on,
                                    c_if.hsync, c_if.vsync, c_if.frame_start}, e);
            end
            // First full line of the 640x480 instance: blanking and hsync window.
            if (reset_n && !line_done && a_if.p_tick) begin
                if (tick_a < H_TOTAL) begin
                    if (!a_if.video_on) vid_off++;
                    if (!a_if.hsync) begin
                        hs_low++;
                        if (first_low_x < 0) first_low_x = int'(a_if.pixel_x);
                    end else if (!hs_prev && back_high_x < 0) begin
                        back_high_x = int'(a_if.pixel_x);
                    end
                    hs_prev = a_if.hsync;
                end else begin
                    check_int("line_wrap_x", int'(a_if.pixel_x), 0);
                    check_int("line_wrap_y", int'(a_if.pixel_y), 1);
                    check_int("blank_ticks", vid_off, H_TOTAL - H_DISPLAY);
                    check_int("hsync_low_ticks", hs_low, H_SYNC);
                    check_int("hsync_first_low_x", first_low_x, H_SYNC_START);
                    check_int("hsync_high_again_x", back_high_x, H_SYNC_END + 1);
                    line_done = 1'b1;
                end
                tick_a++;
            end
        end
    end

    // ---------------- driver ----------------
    initial begin : driver
        int run;
        int hold;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 reset_n = 1'b1;
        // Long first run: covers many lines of the 640x480 instance and many
        // frames (including the bottom-right wrap) of the small ones.
        repeat (20000) @(posedge clk);
        for (int s = 0; s < 5; s++) begin
            run  = $urandom_range(100, 3000);
            hold = $urandom_range(1, 3);
            repeat (run) @(posedge clk);
            #2 reset_n = 1'b0;
            repeat (hold) @(posedge clk);
            @(negedge clk);
            #2 reset_n = 1'b1;
        end
        repeat (3000) @(posedge clk);
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
